// File: rtl/preif_fetch_gen.sv
// Pre-IF fetch stage: owns the fetch PC, arbitrates redirects, issues group-aligned
// inst-cache requests and hands {pc, slot mask, ADEF, cancel} to the IF stage.
module preif_fetch_gen #(
   parameter int              PC_W      = 32,
   parameter int              FETCH_W   = 2,
   parameter logic [PC_W-1:0] RESET_PC  = 32'h1c000000,
   parameter int              EXCT_W    = 7,
   parameter logic [EXCT_W-1:0] ADEF_CODE = 7'h08
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                next_allowin_i,
   input  logic                excep_flush_i,
   input  logic                excep_en_i,
   input  logic [PC_W-1:0]     excep_pc_i,
   input  logic                tlb_refetch_en_i,
   input  logic [PC_W-1:0]     tlb_refetch_pc_i,
   input  logic                ertn_en_i,
   input  logic [PC_W-1:0]     ertn_pc_i,
   input  logic                branch_en_i,
   input  logic [PC_W-1:0]     branch_pc_i,
   input  logic                inst_sram_addr_ok_i,
   output logic                inst_sram_req_o,
   output logic [PC_W-1:0]     inst_sram_raddr_o,
   output logic                to_next_valid_o,
   output logic [PC_W-1:0]     to_next_pc_o,
   output logic [FETCH_W-1:0]  to_next_mask_o,
   output logic                to_next_excp_o,
   output logic [EXCT_W-1:0]   to_next_excp_type_o,
   output logic                to_next_cancel_o
);

   localparam int GB = 4 * FETCH_W;
   localparam logic [PC_W-1:0] GB_MASK = PC_W'(GB - 1);
   localparam logic [PC_W-1:0] GB_STEP = PC_W'(GB);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_EXC  = 2'd2
   } state_t;

   state_t          st;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] hold_pc;
   logic            cancel_q;

   logic            redir;
   logic [PC_W-1:0] rpc;
   logic [PC_W-1:0] cand;
   logic [PC_W-1:0] aligned;
   logic [PC_W-1:0] hold_aligned;
   logic            cand_misaligned;

   // Slot i of a group is valid when it sits at or after the word the PC points at.
   function automatic logic [FETCH_W-1:0] slot_mask(input logic [PC_W-1:0] pc);
      logic [PC_W-1:0] slot;
      logic [FETCH_W-1:0] m;
      slot = (pc & GB_MASK) >> 2;
      m = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         m[i] = (PC_W'(i) >= slot);
      end
      return m;
   endfunction

   // Redirect arbitration: exception > TLB refetch > ertn > branch.
   always_comb begin
      redir = excep_en_i | tlb_refetch_en_i | ertn_en_i | branch_en_i;
      if (excep_en_i) begin
         rpc = excep_pc_i;
      end else if (tlb_refetch_en_i) begin
         rpc = tlb_refetch_pc_i;
      end else if (ertn_en_i) begin
         rpc = ertn_pc_i;
      end else if (branch_en_i) begin
         rpc = branch_pc_i;
      end else begin
         rpc = pc_q;
      end
      cand            = redir ? rpc : pc_q;
      aligned         = cand & ~GB_MASK;
      hold_aligned    = hold_pc & ~GB_MASK;
      cand_misaligned = (cand[1:0] != 2'b00);
   end

   // Request and IF handoff; combinational so the handoff lands in the addr_ok cycle.
   always_comb begin
      inst_sram_req_o     = 1'b0;
      inst_sram_raddr_o   = '0;
      to_next_valid_o     = 1'b0;
      to_next_pc_o        = '0;
      to_next_mask_o      = '0;
      to_next_excp_o      = 1'b0;
      to_next_excp_type_o = '0;
      to_next_cancel_o    = 1'b0;
      if (rst) begin
         inst_sram_req_o = 1'b0;
      end else begin
         case (st)
            ST_RUN: begin
               if (excep_flush_i || !next_allowin_i) begin
                  inst_sram_req_o = 1'b0;
               end else if (cand_misaligned) begin
                  to_next_valid_o     = 1'b1;
                  to_next_pc_o        = cand;
                  to_next_excp_o      = 1'b1;
                  to_next_excp_type_o = ADEF_CODE;
               end else begin
                  inst_sram_req_o   = 1'b1;
                  inst_sram_raddr_o = aligned;
                  if (inst_sram_addr_ok_i) begin
                     to_next_valid_o = 1'b1;
                     to_next_pc_o    = cand;
                     to_next_mask_o  = slot_mask(cand);
                  end else begin
                     to_next_valid_o = 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               // A committed request stays on the bus whatever else happens.
               inst_sram_req_o   = 1'b1;
               inst_sram_raddr_o = hold_aligned;
               if (inst_sram_addr_ok_i) begin
                  to_next_valid_o  = 1'b1;
                  to_next_pc_o     = hold_pc;
                  to_next_mask_o   = slot_mask(hold_pc);
                  to_next_cancel_o = cancel_q | excep_flush_i | redir;
               end else begin
                  to_next_valid_o = 1'b0;
               end
            end
            ST_EXC: begin
               inst_sram_req_o = 1'b0;
            end
            default: begin
               inst_sram_req_o = 1'b0;
            end
         endcase
      end
   end

   // Fetch-PC, hold and cancel state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_RUN;
         pc_q     <= RESET_PC;
         hold_pc  <= RESET_PC;
         cancel_q <= 1'b0;
      end else begin
         case (st)
            ST_RUN: begin
               if (excep_flush_i || !next_allowin_i) begin
                  pc_q <= cand;
               end else if (cand_misaligned) begin
                  pc_q <= cand;
                  st   <= ST_EXC;
               end else if (inst_sram_addr_ok_i) begin
                  pc_q <= aligned + GB_STEP;
               end else begin
                  pc_q     <= cand;
                  hold_pc  <= cand;
                  cancel_q <= 1'b0;
                  st       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (inst_sram_addr_ok_i) begin
                  // A stale in-flight group must not advance the PC past a pending redirect.
                  if (redir) begin
                     pc_q <= rpc;
                  end else if (cancel_q) begin
                     pc_q <= pc_q;
                  end else begin
                     pc_q <= hold_aligned + GB_STEP;
                  end
                  cancel_q <= 1'b0;
                  st       <= ST_RUN;
               end else if (redir || excep_flush_i) begin
                  cancel_q <= 1'b1;
                  if (redir) begin
                     pc_q <= rpc;
                  end else begin
                     pc_q <= pc_q;
                  end
               end else begin
                  cancel_q <= cancel_q;
               end
            end
            ST_EXC: begin
               if (redir) begin
                  pc_q <= rpc;
                  st   <= ST_RUN;
               end else begin
                  st <= ST_EXC;
               end
            end
            default: begin
               st       <= ST_RUN;
               cancel_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_preif_fetch_gen.sv
// Directed bench for preif_fetch_gen (FETCH_W=2, GB=8): inputs change just after the
// falling edge, combinational outputs are checked 1 ns later.
module tb_preif_fetch_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        next_allowin_i;
   logic        excep_flush_i;
   logic        excep_en_i;
   logic [31:0] excep_pc_i;
   logic        tlb_refetch_en_i;
   logic [31:0] tlb_refetch_pc_i;
   logic        ertn_en_i;
   logic [31:0] ertn_pc_i;
   logic        branch_en_i;
   logic [31:0] branch_pc_i;
   logic        inst_sram_addr_ok_i;
   logic        inst_sram_req_o;
   logic [31:0] inst_sram_raddr_o;
   logic        to_next_valid_o;
   logic [31:0] to_next_pc_o;
   logic [1:0]  to_next_mask_o;
   logic        to_next_excp_o;
   logic [6:0]  to_next_excp_type_o;
   logic        to_next_cancel_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   preif_fetch_gen dut (
      .clk                 (clk),
      .rst                 (rst),
      .next_allowin_i      (next_allowin_i),
      .excep_flush_i       (excep_flush_i),
      .excep_en_i          (excep_en_i),
      .excep_pc_i          (excep_pc_i),
      .tlb_refetch_en_i    (tlb_refetch_en_i),
      .tlb_refetch_pc_i    (tlb_refetch_pc_i),
      .ertn_en_i           (ertn_en_i),
      .ertn_pc_i           (ertn_pc_i),
      .branch_en_i         (branch_en_i),
      .branch_pc_i         (branch_pc_i),
      .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
      .inst_sram_req_o     (inst_sram_req_o),
      .inst_sram_raddr_o   (inst_sram_raddr_o),
      .to_next_valid_o     (to_next_valid_o),
      .to_next_pc_o        (to_next_pc_o),
      .to_next_mask_o      (to_next_mask_o),
      .to_next_excp_o      (to_next_excp_o),
      .to_next_excp_type_o (to_next_excp_type_o),
      .to_next_cancel_o    (to_next_cancel_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle: go to the next falling edge, which follows one rising edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic quiet();
      excep_flush_i    = 1'b0;
      excep_en_i       = 1'b0;
      tlb_refetch_en_i = 1'b0;
      ertn_en_i        = 1'b0;
      branch_en_i      = 1'b0;
   endtask

   // Check a fetch that is accepted in the same cycle.
   task automatic chk_fetch(input string tag, input logic [31:0] raddr, input logic [31:0] pc,
                            input logic [1:0] mask);
      #1;
      chk({tag, "_req"},   {31'd0, inst_sram_req_o}, 32'd1);
      chk({tag, "_raddr"}, inst_sram_raddr_o, raddr);
      chk({tag, "_valid"}, {31'd0, to_next_valid_o}, 32'd1);
      chk({tag, "_pc"},    to_next_pc_o, pc);
      chk({tag, "_mask"},  {30'd0, to_next_mask_o}, {30'd0, mask});
      chk({tag, "_cancel"},{31'd0, to_next_cancel_o}, 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      #1;
      chk({tag, "_req"},   {31'd0, inst_sram_req_o}, 32'd0);
      chk({tag, "_valid"}, {31'd0, to_next_valid_o}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      next_allowin_i      = 1'b1;
      inst_sram_addr_ok_i = 1'b1;
      excep_pc_i = 32'd0; tlb_refetch_pc_i = 32'd0; ertn_pc_i = 32'd0; branch_pc_i = 32'd0;
      quiet();
      step();
      chk_idle("reset");
      step();
      chk_idle("reset2");

      // Sequential fetch from the reset PC.
      step(); rst = 1'b0;
      chk_fetch("seq0", 32'h1c000000, 32'h1c000000, 2'b11);
      step();
      chk_fetch("seq1", 32'h1c000008, 32'h1c000008, 2'b11);
      step();
      chk_fetch("seq2", 32'h1c000010, 32'h1c000010, 2'b11);

      // Branch into the second slot.
      step(); branch_en_i = 1'b1; branch_pc_i = 32'h1c000104;
      chk_fetch("br", 32'h1c000100, 32'h1c000104, 2'b10);
      step(); quiet();
      chk_fetch("br_next", 32'h1c000108, 32'h1c000108, 2'b11);

      // Stall at 1c000010, redirect to 1c000200 while the request is held.
      step(); branch_en_i = 1'b1; branch_pc_i = 32'h1c000010; inst_sram_addr_ok_i = 1'b0;
      #1;
      chk("hold1_raddr", inst_sram_raddr_o, 32'h1c000010);
      chk("hold1_valid", {31'd0, to_next_valid_o}, 32'd0);
      step(); branch_pc_i = 32'h1c000200;
      #1;
      chk("hold2_req",   {31'd0, inst_sram_req_o}, 32'd1);
      chk("hold2_raddr", inst_sram_raddr_o, 32'h1c000010);
      step(); quiet();
      #1;
      chk("hold3_raddr", inst_sram_raddr_o, 32'h1c000010);
      chk("hold3_valid", {31'd0, to_next_valid_o}, 32'd0);
      step(); inst_sram_addr_ok_i = 1'b1;
      #1;
      chk("acc_valid",  {31'd0, to_next_valid_o}, 32'd1);
      chk("acc_pc",     to_next_pc_o, 32'h1c000010);
      chk("acc_cancel", {31'd0, to_next_cancel_o}, 32'd1);
      step();
      chk_fetch("after_cancel", 32'h1c000200, 32'h1c000200, 2'b11);

      // Exception beats branch.
      step(); branch_en_i = 1'b1; branch_pc_i = 32'h1c000300;
      excep_en_i = 1'b1; excep_pc_i = 32'h1c008000;
      chk_fetch("prio", 32'h1c008000, 32'h1c008000, 2'b11);

      // Misaligned ertn target raises ADEF and parks in EXC.
      step(); quiet(); ertn_en_i = 1'b1; ertn_pc_i = 32'h1c000102;
      #1;
      chk("adef_req",   {31'd0, inst_sram_req_o}, 32'd0);
      chk("adef_valid", {31'd0, to_next_valid_o}, 32'd1);
      chk("adef_excp",  {31'd0, to_next_excp_o}, 32'd1);
      chk("adef_type",  {25'd0, to_next_excp_type_o}, 32'h08);
      chk("adef_pc",    to_next_pc_o, 32'h1c000102);
      chk("adef_mask",  {30'd0, to_next_mask_o}, 32'd0);
      step(); quiet();
      chk_idle("exc_idle");
      step(); excep_flush_i = 1'b1;
      chk_idle("exc_flush");
      step(); quiet(); excep_en_i = 1'b1; excep_pc_i = 32'h1c001000;
      chk_idle("exc_redir");
      step(); quiet();
      chk_fetch("exc_exit", 32'h1c001000, 32'h1c001000, 2'b11);

      // IF back-pressure holds the PC.
      step(); next_allowin_i = 1'b0;
      chk_idle("noallow");
      step(); next_allowin_i = 1'b1;
      chk_fetch("allow", 32'h1c001008, 32'h1c001008, 2'b11);

      // Wrap-around at the top of the address space.
      step(); branch_en_i = 1'b1; branch_pc_i = 32'hfffffffc;
      chk_fetch("wrap0", 32'hfffffff8, 32'hfffffffc, 2'b10);
      step(); quiet();
      chk_fetch("wrap1", 32'h00000000, 32'h00000000, 2'b11);

      // Reset in WAIT.
      step(); inst_sram_addr_ok_i = 1'b0;
      #1;
      chk("wait_raddr", inst_sram_raddr_o, 32'h00000008);
      step(); rst = 1'b1;
      chk_idle("rst_wait");
      step(); rst = 1'b0; inst_sram_addr_ok_i = 1'b1;
      chk_fetch("rst_resume", 32'h1c000000, 32'h1c000000, 2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
